apb_to_wb_bridge: RTL and testbench



---
 rtl/apb_to_wb_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_apb_to_wb_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_wb_bridge.sv
// apb_to_wb_bridge
//   APB4 slave that turns each APB access into one Wishbone pipelined cycle
//   (a single accepted strobe, then a wait for ack/err/rty). A timeout counter
//   forces an error if the slave never terminates. All outputs are registered.
//
//   Optional build macro APB2WB_RETRY_EN: wb_rty_i reissues the strobe up to
//   RETRY_MAX times before reporting an error. Without it, wb_rty_i is an error.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   psel_i .. pstrb_i       APB request
//   pready_o, prdata_o,
//   pslverr_o               APB response (pready_o is a one-cycle pulse)
//   wb_cyc_o .. wb_dat_o    Wishbone master request
//   wb_dat_i .. wb_stall_i  Wishbone slave response
module apb_to_wb_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned RETRY_MAX  = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   input  logic [31:0]           pwdata_i,
   input  logic [3:0]            pstrb_i,
   output logic                  pready_o,
   output logic [31:0]           prdata_o,
   output logic                  pslverr_o,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [3:0]            wb_sel_o,
   output logic                  wb_we_o,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic                  wb_rty_i,
   input  logic                  wb_stall_i
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

   state_e                state_q, state_d;
   logic                  cyc_q, cyc_d;
   logic                  stb_q, stb_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [3:0]            sel_q, sel_d;
   logic [31:0]           wdat_q, wdat_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [15:0]           tmo_q, tmo_d;

`ifdef APB2WB_RETRY_EN
   localparam int unsigned RetryW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam logic [RetryW-1:0] RetryLast = RetryW'(RETRY_MAX);
   logic [RetryW-1:0] retry_q, retry_d;
`endif

   logic live;   // slave has accepted the strobe, so terminations are meaningful
   logic done;
   logic fail;

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      sel_d     = sel_q;
      wdat_d    = wdat_q;
      rdata_d   = rdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      tmo_d     = tmo_q;
      live      = 1'b0;
      done      = 1'b0;
      fail      = 1'b0;
`ifdef APB2WB_RETRY_EN
      retry_d   = retry_q;
`endif
      unique case (state_q)
         StIdle: begin
`ifdef APB2WB_RETRY_EN
            retry_d = '0;
`endif
            // Only a setup phase starts a cycle; access phases seen here are ignored.
            if (psel_i && !penable_i) begin
               adr_d   = paddr_i;
               wdat_d  = pwdata_i;
               we_d    = pwrite_i;
               sel_d   = pwrite_i ? pstrb_i : 4'hF;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               tmo_d   = '0;
               state_d = StReq;
            end
         end
         StReq, StWait: begin
            tmo_d = tmo_q + 16'd1;
            live  = (state_q == StWait) || !wb_stall_i;
            if ((state_q == StReq) && !wb_stall_i) begin
               stb_d   = 1'b0;
               state_d = StWait;
            end
            // err > rty > ack > timeout
            if (live && wb_err_i) begin
               done = 1'b1;
               fail = 1'b1;
            end else if (live && wb_rty_i) begin
`ifdef APB2WB_RETRY_EN
               if (retry_q == RetryLast) begin
                  done = 1'b1;
                  fail = 1'b1;
               end else begin
                  state_d = StReq;
                  stb_d   = 1'b1;
                  tmo_d   = '0;
                  retry_d = retry_q + RetryW'(1);
               end
`else
               done = 1'b1;
               fail = 1'b1;
`endif
            end else if (live && wb_ack_i) begin
               done = 1'b1;
               if (!we_q) begin
                  rdata_d = wb_dat_i;
               end
            end else if (tmo_q == TmoLast) begin
               done = 1'b1;
               fail = 1'b1;
            end
            if (done) begin
               state_d   = StDone;
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               pready_d  = 1'b1;
               pslverr_d = fail;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         wdat_q    <= '0;
         rdata_q   <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         tmo_q     <= '0;
`ifdef APB2WB_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         wdat_q    <= wdat_d;
         rdata_q   <= rdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         tmo_q     <= tmo_d;
`ifdef APB2WB_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign pready_o  = pready_q;
   assign prdata_o  = rdata_q;
   assign pslverr_o = pslverr_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = stb_q;
   assign wb_adr_o  = adr_q;
   assign wb_sel_o  = sel_q;
   assign wb_we_o   = we_q;
   assign wb_dat_o  = wdat_q;

endmodule

// File: tb/tb_apb_to_wb_bridge.sv
// Testbench for apb_to_wb_bridge: directed APB accesses against a small
// Wishbone register-bank model (reg0 @0x0, reg1 @0x4 resetting to 0x123).
// Expected responses are queued at issue time and checked by a monitor.
`timescale 1ns/1ps
module tb_apb_to_wb_bridge;

   localparam int unsigned AW = 32;

   // slave response modes
   localparam int ModeAck  = 0;
   localparam int ModeErr  = 1;
   localparam int ModeNone = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [31:0]   pwdata;
   logic [3:0]    pstrb;
   logic          pready_o, pslverr_o;
   logic [31:0]   prdata_o;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0] wb_adr_o;
   logic [3:0]    wb_sel_o;
   logic [31:0]   wb_dat_o;
   logic [31:0]   wb_dat_i;
   logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

   apb_to_wb_bridge #(
      .ADDR_WIDTH(AW),
      .TIMEOUT   (16),
      .RETRY_MAX (3)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .psel_i    (psel),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .pstrb_i   (pstrb),
      .pready_o  (pready_o),
      .prdata_o  (prdata_o),
      .pslverr_o (pslverr_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_adr_o  (wb_adr_o),
      .wb_sel_o  (wb_sel_o),
      .wb_we_o   (wb_we_o),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_i  (wb_ack_i),
      .wb_err_i  (wb_err_i),
      .wb_rty_i  (wb_rty_i),
      .wb_stall_i(wb_stall_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc_n    = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          strobes;
      int          stb_cycles;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] adr;
      int          setup;
   } exp_t;

   exp_t sb_q[$];

   // slave model state
   int          s_mode = ModeAck;
   int          stall_left = 0;
   int          rty_left = 0;
   bit          pending = 1'b0;
   int          accepts = 0;
   int          stb_cnt = 0;
   logic [3:0]  last_sel;
   logic        last_we;
   logic [31:0] last_adr;
   logic [31:0] last_dat;
   logic [31:0] mem [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc_n++;
      end
   end

   // Wishbone slave: stall is decided within the strobe cycle, the response
   // comes in the cycle after the strobe is accepted.
   initial begin
      int idx;
      wb_dat_i   = 32'hBAD0_BAD0;
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_rty_i   = 1'b0;
      wb_stall_i = 1'b0;
      mem[0]     = 32'h0;
      mem[1]     = 32'h0000_0123;
      forever begin
         @(negedge clk);
         wb_ack_i   = 1'b0;
         wb_err_i   = 1'b0;
         wb_rty_i   = 1'b0;
         wb_stall_i = 1'b0;
         wb_dat_i   = 32'hBAD0_BAD0;
         if (!rst_n) begin
            mem[0]  = 32'h0;
            mem[1]  = 32'h0000_0123;
            pending = 1'b0;
         end else begin
            if (pending) begin
               pending = 1'b0;
               if (rty_left > 0) begin
                  wb_rty_i = 1'b1;
                  rty_left--;
               end else if (s_mode == ModeAck) begin
                  wb_ack_i = 1'b1;
                  idx = int'(last_adr[2]);
                  if (last_we) begin
                     for (int b = 0; b < 4; b++) begin
                        if (last_sel[b]) mem[idx][8*b +: 8] = last_dat[8*b +: 8];
                     end
                  end else begin
                     wb_dat_i = mem[idx];
                  end
               end else if (s_mode == ModeErr) begin
                  wb_err_i = 1'b1;
               end
            end
            if (wb_cyc_o && wb_stb_o) begin
               stb_cnt++;
               if (stall_left > 0) begin
                  wb_stall_i = 1'b1;
                  stall_left--;
               end else begin
                  pending  = 1'b1;
                  accepts++;
                  last_sel = wb_sel_o;
                  last_we  = wb_we_o;
                  last_adr = wb_adr_o;
                  last_dat = wb_dat_o;
               end
            end
         end
      end
   end

   // Monitor: every pready pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      logic prev_pready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && pready_o) begin
            check("pready_pulse", {31'b0, prev_pready}, 32'h0);
            if (sb_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_pready: got pready=1 at cycle %0d, required none", cyc_n);
            end else begin
               e = sb_q.pop_front();
               check("pslverr", {31'b0, pslverr_o}, {31'b0, e.err});
               check("prdata", prdata_o, e.rdata);
               check("latency", cyc_n - e.setup, e.lat);
               check("strobes_accepted", accepts, e.strobes);
               check("stb_cycles", stb_cnt, e.stb_cycles);
               check("wb_sel", {28'b0, last_sel}, {28'b0, e.sel});
               check("wb_we", {31'b0, last_we}, {31'b0, e.we});
               check("wb_adr", last_adr, e.adr);
               check("cyc_stb_at_ready", {30'b0, wb_cyc_o, wb_stb_o}, 32'h0);
            end
         end
         prev_pready = pready_o;
      end
   end

   task automatic apb_setup(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                            input logic [3:0] strb, input int mode, input int stall,
                            input int nrty);
      @(posedge clk);
      #1;
      s_mode     = mode;
      stall_left = stall;
      rty_left   = nrty;
      accepts    = 0;
      stb_cnt    = 0;
      psel       = 1'b1;
      penable    = 1'b0;
      pwrite     = we;
      paddr      = adr;
      pwdata     = wdat;
      pstrb      = strb;
   endtask

   task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] strb, input int mode, input int stall, input int nrty,
                      input logic x_err, input logic [31:0] x_rdata, input int x_lat,
                      input int x_acc, input int x_stb, input logic [3:0] x_sel);
      exp_t e;
      bit   got;
      apb_setup(adr, we, wdat, strb, mode, stall, nrty);
      e.err        = x_err;
      e.rdata      = x_rdata;
      e.lat        = x_lat;
      e.strobes    = x_acc;
      e.stb_cycles = x_stb;
      e.sel        = x_sel;
      e.we         = we;
      e.adr        = adr;
      e.setup      = cyc_n;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      penable = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pready_o) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_err++;
         $display("FAIL pready_wait: got no pready in 200 cycles for addr %h, required one", adr);
      end
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready", {31'b0, pready_o}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr_o}, 32'h0);
      check("rst_prdata", prdata_o, 32'h0);
      check("rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'h0);
      check("rst_adr", wb_adr_o, 32'h0);
      check("rst_sel_we", {27'b0, wb_sel_o, wb_we_o}, 32'h0);
      check("rst_dat", wb_dat_o, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      //   addr          we    wdata          strb   mode      stl rty err   rdata          lat acc stb sel
      txn(32'h4, 1'b0, 32'h0,        4'h0, ModeAck,  0, 0, 1'b0, 32'h0000_0123, 3,  1, 1, 4'hF);
      txn(32'h0, 1'b1, 32'hDEADBEEF, 4'hF, ModeAck,  0, 0, 1'b0, 32'h0000_0123, 3,  1, 1, 4'hF);
      txn(32'h0, 1'b0, 32'h0,        4'h0, ModeAck,  0, 0, 1'b0, 32'hDEADBEEF,  3,  1, 1, 4'hF);
      txn(32'h4, 1'b1, 32'h0000AA55, 4'h3, ModeAck,  5, 0, 1'b0, 32'hDEADBEEF,  8,  1, 6, 4'h3);
      txn(32'h4, 1'b0, 32'h0,        4'h0, ModeAck,  0, 0, 1'b0, 32'h0000_AA55, 3,  1, 1, 4'hF);
      txn(32'h8, 1'b0, 32'h0,        4'h0, ModeNone, 0, 0, 1'b1, 32'h0000_AA55, 17, 1, 1, 4'hF);
      check("cyc_after_timeout", {31'b0, wb_cyc_o}, 32'h0);
      txn(32'h0, 1'b0, 32'h0,        4'h0, ModeErr,  0, 0, 1'b1, 32'h0000_AA55, 3,  1, 1, 4'hF);
`ifdef APB2WB_RETRY_EN
      txn(32'h0, 1'b0, 32'h0,        4'h0, ModeNone, 0, 4, 1'b1, 32'h0000_AA55, 9,  4, 4, 4'hF);
      txn(32'h0, 1'b0, 32'h0,        4'h0, ModeAck,  0, 1, 1'b0, 32'hDEADBEEF,  5,  2, 2, 4'hF);
`else
      txn(32'h0, 1'b0, 32'h0,        4'h0, ModeAck,  0, 1, 1'b1, 32'h0000_AA55, 3,  1, 1, 4'hF);
      txn(32'h0, 1'b0, 32'h0,        4'h0, ModeAck,  0, 0, 1'b0, 32'hDEADBEEF,  3,  1, 1, 4'hF);
`endif

      // Reset while waiting for a slave that never answers: no pready expected.
      apb_setup(32'h4, 1'b0, 32'h0, 4'h0, ModeNone, 0, 0);
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(posedge clk);
      #1;
      check("wait_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'h2);
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'h0);
      check("midrst_pready", {31'b0, pready_o}, 32'h0);
      check("midrst_prdata", prdata_o, 32'h0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      txn(32'h4, 1'b0, 32'h0,        4'h0, ModeAck,  0, 0, 1'b0, 32'h0000_0123, 3,  1, 1, 4'hF);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sb_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
